// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types for the PWM pattern sequencer.
//   pwm_state_e : sequencer FSM states (IDLE/LOAD/RUN/DONE)
//   pwm_entry_t : one pattern-table entry {period, duty, rpt}
//   ENTRY_RST   : value every table entry takes in reset
// Period/duty fields are sized for the widest supported CW; narrower
// instances zero-extend on write and truncate on read.
package pwm_seq_pkg;

  localparam int unsigned PWM_CW_MAX = 32;
  localparam int unsigned RPT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pwm_state_e;

  typedef struct packed {
    logic [PWM_CW_MAX-1:0] period;
    logic [PWM_CW_MAX-1:0] duty;
    logic [RPT_W-1:0]      rpt;
  } pwm_entry_t;

  localparam pwm_entry_t ENTRY_RST = '{period: '0, duty: '0, rpt: '0};

endpackage

// File: rtl/pwm_seq_table.sv
// pwm_seq_table: DEPTH x pwm_entry_t register file for the sequencer.
// Ports:
//   HCLK, HRESETn : clock, async active-low reset (all entries cleared)
//   i_we, i_waddr, i_wdata : single write port
//   i_raddr, o_rdata_c     : asynchronous (combinational) read port
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  pwm_entry_t                 i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output pwm_entry_t                 o_rdata_c
);

  pwm_entry_t r_mem [DEPTH];

  // Storage: cleared in reset, one entry written per cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= ENTRY_RST;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: plays a table of PWM entries {period, duty, rpt} in order,
// optionally looping, with one low LOAD cycle between entries.
// Ports:
//   HCLK, HRESETn          : clock, async active-low reset
//   cfg_we/addr/period/duty/rpt : pattern-table write port (any state)
//   num_entries, loop_en   : entries to play (clamped to DEPTH), wrap enable
//   start, stop            : command pulses (stop wins)
//   pwm_o, busy_o, entry_o, done_o : registered status/waveform
//   irq_clr, irq_o         : only when PWM_SEQ_IRQ_EN is defined; sticky
//                            completion/loop-wrap interrupt
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [CW-1:0]              cfg_period,
  input  logic [CW-1:0]              cfg_duty,
  input  logic [7:0]                 cfg_rpt,
  input  logic [$clog2(DEPTH):0]     num_entries,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       stop,
  output logic                       pwm_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH)-1:0]   entry_o,
  output logic                       done_o
`ifdef PWM_SEQ_IRQ_EN
  ,
  input  logic                       irq_clr,
  output logic                       irq_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  pwm_state_e        r_state, w_state_nxt;
  logic [AW-1:0]     r_idx, w_idx_nxt;
  logic [CW-1:0]     r_period, r_duty, r_cnt;
  logic [RPT_W-1:0]  r_rpt, r_rpt_cnt;
  logic              r_pwm, r_busy, r_done;
  logic [NW-1:0]     w_num;
  logic              w_wrap;
  logic              w_loop_wrap;
  pwm_entry_t        w_wdata, w_rd;
  logic              w_unused_rd;

  assign w_wdata = '{period: PWM_CW_MAX'(cfg_period),
                     duty:   PWM_CW_MAX'(cfg_duty),
                     rpt:    cfg_rpt};

  pwm_seq_table #(.DEPTH(DEPTH)) u_table (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .i_we      (cfg_we),
    .i_waddr   (cfg_addr),
    .i_wdata   (w_wdata),
    .i_raddr   (r_idx),
    .o_rdata_c (w_rd)
  );

  // Upper field bits beyond CW are always zero
  assign w_unused_rd = ^{w_rd.period, w_rd.duty};

  assign w_num  = (num_entries > NW'(DEPTH)) ? NW'(DEPTH) : num_entries;
  // >= keeps the counter bounded even if period shrinks below it
  assign w_wrap = (r_state == RUN) && (r_cnt >= r_period);

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and entry-index selection; stop overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_loop_wrap = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (num_entries != '0)) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end
      end
      LOAD: w_state_nxt = RUN;
      RUN: begin
        if (w_wrap) begin
          if (r_rpt_cnt < r_rpt) begin
            w_state_nxt = RUN;
          end else if ((NW'(r_idx) + NW'(1)) < w_num) begin
            w_idx_nxt   = r_idx + AW'(1);
            w_state_nxt = LOAD;
          end else if (loop_en) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD;
            w_loop_wrap = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (stop) begin
      w_state_nxt = IDLE;
      w_loop_wrap = 1'b0;
    end
  end

  // Active entry, period counter and repeat counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_period  <= '0;
      r_duty    <= '0;
      r_rpt     <= '0;
      r_cnt     <= '0;
      r_rpt_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_period  <= CW'(w_rd.period);
      r_duty    <= CW'(w_rd.duty);
      r_rpt     <= w_rd.rpt;
      r_cnt     <= '0;
      r_rpt_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_wrap) begin
        r_cnt <= '0;
        if (r_rpt_cnt < r_rpt) begin
          r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Registered outputs; pwm lags the counter by one cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pwm  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_pwm  <= (r_state == RUN) && (r_cnt < r_duty);
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign pwm_o   = r_pwm;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign entry_o = r_idx;

`ifdef PWM_SEQ_IRQ_EN
  logic r_irq;

  // Sticky interrupt: set after DONE or on loop wrap, clear has priority
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_irq <= 1'b0;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end else if ((r_state == DONE) || w_loop_wrap) begin
      r_irq <= 1'b1;
    end
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: directed self-checking bench for pwm_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Capture index t=1 is the sample after the edge that sees start.
module tb_pwm_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_duty = '0;
  logic [7:0]    cfg_rpt = '0;
  logic [AW:0]   num_entries = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pwm_o, busy_o, done_o;
  logic [AW-1:0] entry_o;
`ifdef PWM_SEQ_IRQ_EN
  logic          irq_clr = 1'b0;
  logic          irq_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic          pwm_h   [0:127];
  logic          done_h  [0:127];
  logic          busy_h  [0:127];
  logic [AW-1:0] entry_h [0:127];
`ifdef PWM_SEQ_IRQ_EN
  logic          irq_h   [0:127];
`endif

  pwm_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_rpt     (cfg_rpt),
    .num_entries (num_entries),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .pwm_o       (pwm_o),
    .busy_o      (busy_o),
    .entry_o     (entry_o),
    .done_o      (done_o)
`ifdef PWM_SEQ_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq_o       (irq_o)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input int a, input int p, input int d, input int r);
    cfg_addr   = AW'(a);
    cfg_period = CW'(p);
    cfg_duty   = CW'(d);
    cfg_rpt    = 8'(r);
    cfg_we     = 1'b1;
    step();
    cfg_we     = 1'b0;
  endtask

  // Pulse start, record n samples; optionally strobe cfg_we after sample wr_at
  task automatic capture(input int n, input int wr_at);
    start = 1'b1;
    for (int t = 1; t <= n; t++) begin
      step();
      if (t == 1) start = 1'b0;
      pwm_h[t]   = pwm_o;
      done_h[t]  = done_o;
      busy_h[t]  = busy_o;
      entry_h[t] = entry_o;
`ifdef PWM_SEQ_IRQ_EN
      irq_h[t]   = irq_o;
`endif
      cfg_we = (t == wr_at);
    end
    cfg_we = 1'b0;
  endtask

  function automatic int count_hi(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(pwm_h[i]);
    return c;
  endfunction

  function automatic int count_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(done_h[i]);
    return c;
  endfunction

  function automatic int count_rise(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(pwm_h[i] && !pwm_h[i-1]);
    return c;
  endfunction

  initial begin
    // Reset state
    step();
    step();
    check("rst_pwm",   32'(pwm_o),   0);
    check("rst_busy",  32'(busy_o),  0);
    check("rst_done",  32'(done_o),  0);
    check("rst_entry", 32'(entry_o), 0);
    HRESETn = 1'b1;
    step();

    // Single entry {9,5,2}: three 10-cycle periods, 5 high each
    wr(0, 9, 5, 2);
    num_entries = 3'd1;
    loop_en     = 1'b0;
    pwm_h[0]    = 1'b0;
    capture(40, 0);
    check("t1_first_high", 32'(pwm_h[3]), 1);
    check("t1_pre_high",   32'(pwm_h[2]), 0);
    check("t1_high_cnt",   32'(count_hi(1, 40)), 15);
    check("t1_rises",      32'(count_rise(1, 40)), 3);
    check("t1_second_rise", 32'(pwm_h[13] && !pwm_h[12]), 1);
    check("t1_low_at_8",   32'(pwm_h[8]), 0);
    check("t1_done_at_32", 32'(done_h[32]), 1);
    check("t1_done_cnt",   32'(count_done(1, 40)), 1);
    check("t1_busy_32",    32'(busy_h[32]), 1);
    check("t1_busy_33",    32'(busy_h[33]), 0);

    // Two entries {3,1,0},{7,8,1}: 1-of-4, LOAD gap, 16 high
    wr(0, 3, 1, 0);
    wr(1, 7, 8, 1);
    num_entries = 3'd2;
    capture(30, 0);
    check("t2_e0_high",  32'(pwm_h[3]), 1);
    check("t2_e0_low",   32'(count_hi(4, 6)), 0);
    check("t2_gap",      32'(pwm_h[7]), 0);
    check("t2_e1_high",  32'(count_hi(8, 23)), 16);
    check("t2_end_low",  32'(pwm_h[24]), 0);
    check("t2_entry_0",  32'(entry_h[2]), 0);
    check("t2_entry_1",  32'(entry_h[8]), 1);
    check("t2_done_23",  32'(done_h[23]), 1);
    check("t2_done_cnt", 32'(count_done(1, 30)), 1);

    // Loop mode, stop after 100 cycles
`ifdef PWM_SEQ_IRQ_EN
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("t3_irq_clr0", 32'(irq_o), 0);
`endif
    loop_en = 1'b1;
    capture(100, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_busy_stop", 32'(busy_o), 0);
    check("t3_pwm_lag",   32'(pwm_o), 1);
    check("t3_done_101",  32'(done_o), 0);
    step();
    check("t3_pwm_zero",  32'(pwm_o), 0);
    check("t3_done_102",  32'(done_o), 0);
    check("t3_no_done",   32'(count_done(1, 100)), 0);
    check("t3_entry_29",  32'(entry_h[29]), 1);
    check("t3_entry_45",  32'(entry_h[45]), 0);
`ifdef PWM_SEQ_IRQ_EN
    check("t3_irq_22", 32'(irq_h[22]), 0);
    check("t3_irq_23", 32'(irq_h[23]), 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("t3_irq_cleared", 32'(irq_o), 0);
`endif
    loop_en = 1'b0;

    // Start with stop, then start with zero entries
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t4_ss_busy_a", 32'(busy_o), 0);
    step();
    check("t4_ss_busy_b", 32'(busy_o), 0);
    num_entries = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_n0_busy_a", 32'(busy_o), 0);
    step();
    check("t4_n0_busy_b", 32'(busy_o), 0);

    // Rewrite active entry mid-RUN in loop mode
    wr(0, 9, 5, 0);
    num_entries = 3'd1;
    loop_en     = 1'b1;
    cfg_addr    = 2'd0;
    cfg_period  = 16'd9;
    cfg_duty    = 16'd2;
    cfg_rpt     = 8'd0;
    capture(20, 5);
    check("t5_old_6",  32'(pwm_h[6]), 1);
    check("t5_old_7",  32'(pwm_h[7]), 1);
    check("t5_old_8",  32'(pwm_h[8]), 0);
    check("t5_gap_13", 32'(pwm_h[13]), 0);
    check("t5_new_14", 32'(pwm_h[14]), 1);
    check("t5_new_15", 32'(pwm_h[15]), 1);
    check("t5_new_16", 32'(pwm_h[16]), 0);
    stop = 1'b1;
    step();
    stop    = 1'b0;
    loop_en = 1'b0;
    step();

    // Reset mid-RUN clears outputs and the table
    wr(0, 9, 5, 2);
    num_entries = 3'd1;
    capture(4, 0);
    check("t6_pre_pwm", 32'(pwm_h[4]), 1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_rst_pwm",  32'(pwm_o), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_done", 32'(done_o), 0);
    step();
    HRESETn = 1'b1;
    step();
    check("t6_post_done", 32'(done_o), 0);
    check("t6_post_busy", 32'(busy_o), 0);
    capture(6, 0);
    check("t6_clr_done3", 32'(done_h[3]), 1);
    check("t6_clr_pwm",   32'(count_hi(1, 6)), 0);
    check("t6_clr_busy4", 32'(busy_h[4]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
